processor: RTL and testbench
============================

// Module: processor
// PURPOSE
// - Single-cycle sequential RV64I-subset core: one instruction fetched, decoded, executed and retired per clk.
// - Top level of the sequential design. Only ports are clock and reset.
// - Benches preload state hierarchically through these internals, which must keep these exact names:
//   - register_file[0:31] (64-bit)
//   - inst_mem[0:IMEM_DEPTH-1] (32-bit words)
//   - data_mem[0:DMEM_DEPTH-1] (64-bit)
//   - pc (64-bit)
// PARAMETERS
// IMEM_DEPTH  64  instruction memory words; indexed by pc[log2(IMEM_DEPTH)+1:2]
// DMEM_DEPTH  64  data memory doublewords; indexed by addr[log2(DMEM_DEPTH)+2:3]
// PORTS
// clk    in  1  single clock; all state updates on rising edge
// rst_n  in  1  asynchronous, active-low reset
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - pc <= 0; register_file[0..31] <= 0.
//   - inst_mem and data_mem are not cleared.
//   - Reset mid-execution aborts the current instruction; no register or memory write occurs.
// - Each rising clk with rst_n=1 retires instr = inst_mem[pc index]:
//   - all writes (rd, data_mem, pc) commit at the same edge.
//   - Reads see pre-edge values.
// - Decode by opcode[6:0], funct3[14:12], funct7[31:25]; rd[11:7], rs1[19:15], rs2[24:20].
// - R-type 0110011: rd <= rs1 OP rs2; pc += 4.
//   - add: f3=000, f7=0000000
//   - sub: f3=000, f7=0100000
//   - and: f3=111
//   - or: f3=110
// - addi 0010011/f3=000: rd <= rs1 + sext(imm[31:20]); pc += 4.
// - ld 0000011/f3=011: rd <= data_mem[(rs1+sext(imm[31:20]))>>3]; pc += 4.
// - sd 0100011/f3=011: data_mem[(rs1+sext({instr[31:25],instr[11:7]}))>>3] <= rs2; pc += 4.
// - beq 1100011/f3=000:
//   - if rs1==rs2, pc += sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0});
//   - else pc += 4.
// - Any other encoding (including all-zero or uninitialised words) is a NOP: pc += 4, no state change.
// - Arithmetic rules:
//   - 64-bit two's complement, wrap-around on overflow, no flags.
//   - Addresses use the low index bits only; out-of-range addresses wrap modulo depth.
// - x0:
//   - writes to register_file[0] are discarded;
//   - reads of x0 return 0.
// - Source equal to destination (e.g. add x1,x1,x1) uses the old value; the result lands at the edge.
// - pc advances past the end of inst_mem by wrapping the index; pc itself keeps counting (64-bit).
// - Latency: result visible in register_file the edge after instr is presented (1 cycle per instruction).
// TESTING
// - Reset low, then high; preload x1=10, x2=20, x3=30, inst_mem[0]=add x7,x1,x2 (0x002083B3), inst_mem[1]=add x8,x3,x4 (0x00418433)
//   -> after 2 edges x7=30, x8=30, pc=8; next edge pc=12 (NOP).
// - sub x5,x2,x1 with x1=10, x2=20 -> x5=10; and/or with x1=0xF0, x2=0x3C -> and=0x30, or=0xFC.
// - addi x6,x0,-1 -> x6=0xFFFF_FFFF_FFFF_FFFF; add x0,x1,x2 -> x0 stays 0.
// - sd x1,8(x0) then ld x9,8(x0) with x1=10 -> data_mem[1]=10, x9=10.
// - beq x1,x1,+8 at pc=0 -> pc=8; beq x1,x2,+8 with x1!=x2 -> pc=4.
// - Assert rst_n=0 between clk edges after several instructions -> pc=0 and all registers 0 immediately; memories unchanged.

Source files
------------

// File: rtl/processor.sv
// Single-cycle RV64I-subset core: add/sub/and/or/addi/ld/sd/beq, one instruction retired per clock.
// Encodings outside that subset behave as NOPs. Instruction memory is loaded from outside the block.
module processor #(
    parameter int IMEM_DEPTH = 64,
    parameter int DMEM_DEPTH = 64
) (
    input logic clk,
    input logic rst_n
);
    localparam int IMEM_AW = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW = $clog2(DMEM_DEPTH);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [63:0] register_file [0:31];
    logic [31:0] inst_mem [0:IMEM_DEPTH-1];
    logic [63:0] data_mem [0:DMEM_DEPTH-1];
    logic [63:0] pc;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] rs1_val;
    logic [63:0] rs2_val;
    logic [63:0] imm_i;
    logic [63:0] imm_s;
    logic [63:0] imm_b;
    logic [63:0] mem_addr;
    logic [DMEM_AW-1:0] mem_idx;
    logic [63:0] rd_val;
    logic [63:0] next_pc;
    logic        rd_we;
    logic        mem_we;
    logic        unused_addr_bits;

    assign instr  = inst_mem[pc[IMEM_AW+1:2]];
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign rs1_val = (rs1 == 5'd0) ? '0 : register_file[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : register_file[rs2];

    assign imm_i = {{52{instr[31]}}, instr[31:20]};
    assign imm_s = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    // Loads and stores share one adder; only the immediate format differs.
    assign mem_addr = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
    assign mem_idx  = mem_addr[DMEM_AW+2:3];
    assign unused_addr_bits = ^{mem_addr[63:DMEM_AW+3], mem_addr[2:0]};

    always_comb begin
        rd_we   = 1'b0;
        mem_we  = 1'b0;
        rd_val  = '0;
        next_pc = pc + 64'd4;
        case (opcode)
            OP_REG: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    rd_we  = 1'b1;
                    rd_val = rs1_val + rs2_val;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    rd_we  = 1'b1;
                    rd_val = rs1_val - rs2_val;
                end else if (funct3 == 3'b111) begin
                    rd_we  = 1'b1;
                    rd_val = rs1_val & rs2_val;
                end else if (funct3 == 3'b110) begin
                    rd_we  = 1'b1;
                    rd_val = rs1_val | rs2_val;
                end
            end
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    rd_we  = 1'b1;
                    rd_val = rs1_val + imm_i;
                end
            end
            OP_LOAD: begin
                if (funct3 == 3'b011) begin
                    rd_we  = 1'b1;
                    rd_val = data_mem[mem_idx];
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b011) mem_we = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000 && rs1_val == rs2_val) next_pc = pc + imm_b;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= '0;
            for (int i = 0; i < 32; i++) register_file[i] <= '0;
        end else begin
            pc <= next_pc;
            if (rd_we && rd != 5'd0) register_file[rd] <= rd_val;
        end
    end

    // Data memory has no reset; a store is dropped if reset is held at the edge.
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) data_mem[mem_idx] <= rs2_val;
    end

    // Instruction memory is read-only to the core and simply holds what was loaded.
    always_ff @(posedge clk) begin
        inst_mem <= inst_mem;
    end
endmodule

// File: tb/tb_processor.sv
// Self-checking bench for processor: directed programs plus random programs checked
// against an instruction-level reference model of the RV64I subset.
module tb_processor;
    logic clk;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] m_reg  [0:31];
    logic [31:0] m_imem [0:63];
    logic [63:0] m_dmem [0:63];
    logic [63:0] m_pc;

    processor #(.IMEM_DEPTH(64), .DMEM_DEPTH(64)) dut (
        .clk  (clk),
        .rst_n(rst_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] s2,
                                          input logic [4:0] s1, input logic [2:0] f3,
                                          input logic [4:0] d);
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] s1,
                                          input logic [2:0] f3, input logic [4:0] d,
                                          input logic [6:0] op);
        return {imm, s1, f3, d, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] s2,
                                          input logic [4:0] s1);
        return {imm[11:5], s2, s1, 3'b011, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] off, input logic [4:0] s2,
                                          input logic [4:0] s1);
        return {off[12], off[10:5], s2, s1, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    // Architectural reference: executes the instruction at m_pc on the model state.
    task automatic model_step();
        logic [31:0] ins;
        logic [63:0] a, b, res, nxt, addr;
        logic [63:0] immi, imms, immb;
        int d, s1, s2;
        logic wr;
        ins  = m_imem[int'((m_pc >> 2) % 64)];
        d    = int'(ins[11:7]);
        s1   = int'(ins[19:15]);
        s2   = int'(ins[24:20]);
        a    = (s1 == 0) ? 64'd0 : m_reg[s1];
        b    = (s2 == 0) ? 64'd0 : m_reg[s2];
        immi = {{52{ins[31]}}, ins[31:20]};
        imms = {{52{ins[31]}}, ins[31:25], ins[11:7]};
        immb = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        nxt  = m_pc + 64'd4;
        wr   = 1'b0;
        res  = 64'd0;
        if (ins[6:0] == 7'h33) begin
            if (ins[14:12] == 3'd0 && ins[31:25] == 7'h00) begin wr = 1'b1; res = a + b; end
            else if (ins[14:12] == 3'd0 && ins[31:25] == 7'h20) begin wr = 1'b1; res = a - b; end
            else if (ins[14:12] == 3'd7) begin wr = 1'b1; res = a & b; end
            else if (ins[14:12] == 3'd6) begin wr = 1'b1; res = a | b; end
        end else if (ins[6:0] == 7'h13 && ins[14:12] == 3'd0) begin
            wr = 1'b1; res = a + immi;
        end else if (ins[6:0] == 7'h03 && ins[14:12] == 3'd3) begin
            addr = a + immi;
            wr = 1'b1; res = m_dmem[int'((addr >> 3) % 64)];
        end else if (ins[6:0] == 7'h23 && ins[14:12] == 3'd3) begin
            addr = a + imms;
            m_dmem[int'((addr >> 3) % 64)] = b;
        end else if (ins[6:0] == 7'h63 && ins[14:12] == 3'd0) begin
            if (a == b) nxt = m_pc + immb;
        end
        if (wr && d != 0) m_reg[d] = res;
        m_pc = nxt;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_reg[i] = 64'd0;
        for (int i = 0; i < 64; i++) begin
            m_imem[i] = 32'd0;
            m_dmem[i] = {$urandom, $urandom};
        end
        m_pc = 64'd0;
    endtask

    task automatic push_state();
        for (int i = 1; i < 32; i++) dut.register_file[i] = m_reg[i];
        for (int i = 0; i < 64; i++) begin
            dut.inst_mem[i] = m_imem[i];
            dut.data_mem[i] = m_dmem[i];
        end
    endtask

    task automatic compare_arch(input string tag);
        check({tag, "_pc"}, dut.pc, m_pc);
        for (int i = 0; i < 32; i++)
            check($sformatf("%s_x%0d", tag, i), dut.register_file[i], m_reg[i]);
    endtask

    task automatic compare_dmem(input string tag);
        for (int i = 0; i < 64; i++)
            check($sformatf("%s_dmem%0d", tag, i), dut.data_mem[i], m_dmem[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("reset_pc", dut.pc, 64'd0);
        for (int i = 0; i < 32; i++) check($sformatf("reset_x%0d", i), dut.register_file[i], 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic run(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            @(negedge clk);
            compare_arch(tag);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0] d, s1, s2;
        logic [31:0] w;
        int k;
        k  = int'($urandom_range(0, 9));
        d  = 5'($urandom_range(0, 31));
        s1 = 5'($urandom_range(0, 31));
        s2 = 5'($urandom_range(0, 31));
        case (k)
            0: w = enc_r(7'h00, s2, s1, 3'd0, d);
            1: w = enc_r(7'h20, s2, s1, 3'd0, d);
            2: w = enc_r(7'($urandom), s2, s1, 3'd7, d);
            3: w = enc_r(7'($urandom), s2, s1, 3'd6, d);
            4: w = enc_i(12'($urandom), s1, 3'd0, d, 7'h13);
            5: w = enc_i(12'($urandom), s1, 3'd3, d, 7'h03);
            6: w = enc_s(12'($urandom), s2, s1);
            7: w = enc_b({5'($urandom), 7'($urandom_range(0, 127)), 1'b0}, ($urandom_range(0, 1) == 1) ? s1 : s2, s1);
            default: w = $urandom;
        endcase
        return w;
    endfunction

    initial begin
        rst_n = 1'b0;
        #12;

        // Two adds; second reads an untouched (zero) register, then a NOP.
        do_reset();
        m_reg[1] = 64'd10; m_reg[2] = 64'd20; m_reg[3] = 64'd30;
        m_imem[0] = 32'h002083B3;
        m_imem[1] = 32'h00418433;
        push_state();
        run(2, "add");
        check("add_x7", dut.register_file[7], 64'd30);
        check("add_x8", dut.register_file[8], 64'd30);
        check("add_pc", dut.pc, 64'd8);
        run(1, "nop");
        check("nop_pc", dut.pc, 64'd12);

        // ALU ops, sign-extended immediate, x0 write, source equal to destination.
        do_reset();
        m_reg[1] = 64'd10; m_reg[2] = 64'd20;
        m_imem[0] = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd5);
        m_imem[1] = enc_i(12'h0F0, 5'd0, 3'd0, 5'd1, 7'h13);
        m_imem[2] = enc_i(12'h03C, 5'd0, 3'd0, 5'd2, 7'h13);
        m_imem[3] = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd10);
        m_imem[4] = enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd11);
        m_imem[5] = enc_i(12'hFFF, 5'd0, 3'd0, 5'd6, 7'h13);
        m_imem[6] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd0);
        m_imem[7] = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd1);
        push_state();
        run(8, "alu");
        check("sub_x5", dut.register_file[5], 64'd10);
        check("and_x10", dut.register_file[10], 64'h30);
        check("or_x11", dut.register_file[11], 64'hFC);
        check("addi_x6", dut.register_file[6], 64'hFFFF_FFFF_FFFF_FFFF);
        check("x0_zero", dut.register_file[0], 64'd0);
        check("self_x1", dut.register_file[1], 64'h1E0);

        // Store then load through the same doubleword.
        do_reset();
        m_reg[1] = 64'd10;
        m_imem[0] = enc_s(12'd8, 5'd1, 5'd0);
        m_imem[1] = enc_i(12'd8, 5'd0, 3'd3, 5'd9, 7'h03);
        push_state();
        run(2, "mem");
        check("sd_dmem1", dut.data_mem[1], 64'd10);
        check("ld_x9", dut.register_file[9], 64'd10);
        compare_dmem("mem");

        // Branch taken / not taken.
        do_reset();
        m_reg[1] = 64'd5; m_reg[2] = 64'd7;
        m_imem[0] = enc_b(13'd8, 5'd1, 5'd1);
        push_state();
        run(1, "beq_t");
        check("beq_taken_pc", dut.pc, 64'd8);
        do_reset();
        m_reg[1] = 64'd5; m_reg[2] = 64'd7;
        m_imem[0] = enc_b(13'd8, 5'd2, 5'd1);
        push_state();
        run(1, "beq_nt");
        check("beq_not_taken_pc", dut.pc, 64'd4);

        // Straight-line NOPs past the end of instruction memory.
        do_reset();
        push_state();
        run(66, "wrap");
        check("wrap_pc", dut.pc, 64'd264);

        // Random programs against the model.
        for (int t = 0; t < 4; t++) begin
            do_reset();
            for (int i = 1; i < 32; i++) m_reg[i] = {$urandom, $urandom};
            for (int i = 0; i < 64; i++) m_imem[i] = rand_instr();
            push_state();
            run(250, $sformatf("rnd%0d", t));
            compare_dmem($sformatf("rnd%0d", t));
        end

        // Asynchronous reset between edges; a pending store must not land.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pc", dut.pc, 64'd0);
        for (int i = 0; i < 32; i++) check($sformatf("async_x%0d", i), dut.register_file[i], 64'd0);
        compare_dmem("async");
        for (int i = 0; i < 64; i++) check($sformatf("async_imem%0d", i), 64'(dut.inst_mem[i]), 64'(m_imem[i]));
        m_imem[0] = enc_s(12'd0, 5'd0, 5'd0);
        m_dmem[0] = 64'hDEAD_BEEF_0123_4567;
        dut.inst_mem[0] = m_imem[0];
        dut.data_mem[0] = m_dmem[0];
        @(posedge clk);
        @(negedge clk);
        check("held_pc", dut.pc, 64'd0);
        check("held_dmem0", dut.data_mem[0], 64'hDEAD_BEEF_0123_4567);
        compare_dmem("held");
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
